// File: rtl/decode_exec_reg_if.sv
// Bundle of decode-stage inputs, forwarding sources, hazard controls and
// execute-stage register outputs for the D->E pipeline register.
interface decode_exec_reg_if #(
  parameter int DATA_WID = 64,
  parameter int ADDR_WID = 4
);
  logic [3:0]          D_icode, D_ifun;
  logic [DATA_WID-1:0] D_valC, D_valP;
  logic [ADDR_WID-1:0] D_srcA, D_srcB, D_dstE, D_dstM;
  logic [ADDR_WID-1:0] d_srcA, d_srcB;
  logic [DATA_WID-1:0] rf_valA, rf_valB;
  logic [ADDR_WID-1:0] e_dstE, M_dstM, M_dstE, W_dstM, W_dstE;
  logic [DATA_WID-1:0] e_valE, m_valM, M_valE, W_valM, W_valE;
  logic                stall, bubble;
  logic [3:0]          E_icode, E_ifun;
  logic [DATA_WID-1:0] E_valC, E_valA, E_valB;
  logic [ADDR_WID-1:0] E_srcA, E_srcB, E_dstE, E_dstM;
  logic                load_use;

  // Control is level-sensitive: stall and bubble are sampled on every
  // rising clock with no handshake; stall wins over bubble.
  modport master (
    output D_icode, D_ifun, D_valC, D_valP, D_srcA, D_srcB, D_dstE, D_dstM,
    output rf_valA, rf_valB,
    output e_dstE, e_valE, M_dstM, m_valM, M_dstE, M_valE,
    output W_dstM, W_valM, W_dstE, W_valE,
    output stall, bubble,
    input  d_srcA, d_srcB,
    input  E_icode, E_ifun, E_valC, E_valA, E_valB,
    input  E_srcA, E_srcB, E_dstE, E_dstM,
    input  load_use
  );

  modport slave (
    input  D_icode, D_ifun, D_valC, D_valP, D_srcA, D_srcB, D_dstE, D_dstM,
    input  rf_valA, rf_valB,
    input  e_dstE, e_valE, M_dstM, m_valM, M_dstE, M_valE,
    input  W_dstM, W_valM, W_dstE, W_valE,
    input  stall, bubble,
    output d_srcA, d_srcB,
    output E_icode, E_ifun, E_valC, E_valA, E_valB,
    output E_srcA, E_srcB, E_dstE, E_dstM,
    output load_use
  );
endinterface

// File: rtl/decode_exec_reg.sv
// Decode-to-execute pipeline register with operand forwarding, stall/bubble
// control and load/use hazard detection.
module decode_exec_reg #(
  parameter int                DATA_WID = 64,
  parameter int                ADDR_WID = 4,
  parameter logic [ADDR_WID-1:0] RNONE  = 4'hF
) (
  input logic CLK,
  input logic RST_N,
  decode_exec_reg_if.slave bus
);
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IPOPQ   = 4'hB;

  logic [DATA_WID-1:0] fwdValA, fwdValB;
  logic                useValP;

  assign bus.d_srcA = bus.D_srcA;
  assign bus.d_srcB = bus.D_srcB;
  assign useValP    = (bus.D_icode == ICALL) || (bus.D_icode == IJXX);

  // RNONE on the source side blocks every match, so no dst-side check is needed.
  always_comb begin
    fwdValA = bus.rf_valA;
    if (useValP)                                               fwdValA = bus.D_valP;
    else if (bus.D_srcA != RNONE && bus.D_srcA == bus.e_dstE)  fwdValA = bus.e_valE;
    else if (bus.D_srcA != RNONE && bus.D_srcA == bus.M_dstM)  fwdValA = bus.m_valM;
    else if (bus.D_srcA != RNONE && bus.D_srcA == bus.M_dstE)  fwdValA = bus.M_valE;
    else if (bus.D_srcA != RNONE && bus.D_srcA == bus.W_dstM)  fwdValA = bus.W_valM;
    else if (bus.D_srcA != RNONE && bus.D_srcA == bus.W_dstE)  fwdValA = bus.W_valE;
  end

  always_comb begin
    fwdValB = bus.rf_valB;
    if (bus.D_srcB != RNONE && bus.D_srcB == bus.e_dstE)       fwdValB = bus.e_valE;
    else if (bus.D_srcB != RNONE && bus.D_srcB == bus.M_dstM)  fwdValB = bus.m_valM;
    else if (bus.D_srcB != RNONE && bus.D_srcB == bus.M_dstE)  fwdValB = bus.M_valE;
    else if (bus.D_srcB != RNONE && bus.D_srcB == bus.W_dstM)  fwdValB = bus.W_valM;
    else if (bus.D_srcB != RNONE && bus.D_srcB == bus.W_dstE)  fwdValB = bus.W_valE;
  end

  // Reset forces a bubble even while stalled; otherwise stall holds over bubble.
  always_ff @(posedge CLK) begin
    if (!RST_N || (!bus.stall && bus.bubble)) begin
      bus.E_icode <= INOP;
      bus.E_ifun  <= 4'h0;
      bus.E_valC  <= '0;
      bus.E_valA  <= '0;
      bus.E_valB  <= '0;
      bus.E_srcA  <= RNONE;
      bus.E_srcB  <= RNONE;
      bus.E_dstE  <= RNONE;
      bus.E_dstM  <= RNONE;
    end else if (!bus.stall) begin
      bus.E_icode <= bus.D_icode;
      bus.E_ifun  <= bus.D_ifun;
      bus.E_valC  <= bus.D_valC;
      bus.E_valA  <= fwdValA;
      bus.E_valB  <= fwdValB;
      bus.E_srcA  <= bus.D_srcA;
      bus.E_srcB  <= bus.D_srcB;
      bus.E_dstE  <= bus.D_dstE;
      bus.E_dstM  <= bus.D_dstM;
    end
  end

  assign bus.load_use = ((bus.E_icode == IMRMOVQ) || (bus.E_icode == IPOPQ)) &&
                        (bus.E_dstM != RNONE) &&
                        ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
endmodule

// File: tb/tb_decode_exec_reg.sv
// Randomised and directed checks of decode_exec_reg against a behavioural
// model of the execute-stage register contents.
module tb_decode_exec_reg;
  localparam int DW = 64;
  localparam int AW = 4;
  localparam logic [3:0] RN = 4'hF;

  typedef struct packed {
    logic [3:0]    icode, ifun;
    logic [DW-1:0] valC, valA, valB;
    logic [AW-1:0] srcA, srcB, dstE, dstM;
  } e_t;

  localparam e_t BUBBLE = '{icode: 4'h1, ifun: 4'h0, valC: '0, valA: '0, valB: '0,
                            srcA: RN, srcB: RN, dstE: RN, dstM: RN};

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  e_t   exp_e;

  decode_exec_reg_if #(.DATA_WID(DW), .ADDR_WID(AW)) bus ();
  decode_exec_reg #(.DATA_WID(DW), .ADDR_WID(AW), .RNONE(RN)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus));

  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] model_fwd(input logic [AW-1:0] src,
                                               input logic [DW-1:0] rf);
    logic [AW-1:0] dst [5];
    logic [DW-1:0] val [5];
    dst = '{bus.e_dstE, bus.M_dstM, bus.M_dstE, bus.W_dstM, bus.W_dstE};
    val = '{bus.e_valE, bus.m_valM, bus.M_valE, bus.W_valM, bus.W_valE};
    if (src == RN) return rf;
    for (int i = 0; i < 5; i++) if (dst[i] == src) return val[i];
    return rf;
  endfunction

  function automatic e_t model_next();
    e_t n;
    if (!RST_N) return BUBBLE;
    if (bus.stall) return exp_e;
    if (bus.bubble) return BUBBLE;
    n.icode = bus.D_icode;  n.ifun = bus.D_ifun;  n.valC = bus.D_valC;
    n.valA  = (bus.D_icode == 4'h7 || bus.D_icode == 4'h8) ? bus.D_valP
                                                           : model_fwd(bus.D_srcA, bus.rf_valA);
    n.valB  = model_fwd(bus.D_srcB, bus.rf_valB);
    n.srcA  = bus.D_srcA;  n.srcB = bus.D_srcB;
    n.dstE  = bus.D_dstE;  n.dstM = bus.D_dstM;
    return n;
  endfunction

  function automatic logic model_load_use();
    return (exp_e.icode == 4'h5 || exp_e.icode == 4'hB) && exp_e.dstM != RN &&
           (exp_e.dstM == bus.D_srcA || exp_e.dstM == bus.D_srcB);
  endfunction

  function automatic e_t get_e();
    return '{bus.E_icode, bus.E_ifun, bus.E_valC, bus.E_valA, bus.E_valB,
             bus.E_srcA, bus.E_srcB, bus.E_dstE, bus.E_dstM};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    e_t nx;
    nx = model_next();
    @(posedge CLK);
    exp_e = nx;
    #1;
  endtask

  task automatic clear_inputs();
    bus.D_icode = 4'h1; bus.D_ifun = 4'h0; bus.D_valC = '0; bus.D_valP = '0;
    bus.D_srcA = RN; bus.D_srcB = RN; bus.D_dstE = RN; bus.D_dstM = RN;
    bus.rf_valA = '0; bus.rf_valB = '0;
    bus.e_dstE = RN; bus.M_dstM = RN; bus.M_dstE = RN; bus.W_dstM = RN; bus.W_dstE = RN;
    bus.e_valE = '0; bus.m_valM = '0; bus.M_valE = '0; bus.W_valM = '0; bus.W_valE = '0;
    bus.stall = 1'b0; bus.bubble = 1'b0;
  endtask

  task automatic rand_inputs();
    bus.D_icode = 4'($urandom_range(0, 11)); bus.D_ifun = 4'($urandom);
    bus.D_valC = {$urandom, $urandom}; bus.D_valP = {$urandom, $urandom};
    bus.D_srcA = 4'($urandom); bus.D_srcB = 4'($urandom);
    bus.D_dstE = 4'($urandom); bus.D_dstM = 4'($urandom);
    bus.rf_valA = {$urandom, $urandom}; bus.rf_valB = {$urandom, $urandom};
    bus.e_dstE = 4'($urandom); bus.M_dstM = 4'($urandom); bus.M_dstE = 4'($urandom);
    bus.W_dstM = 4'($urandom); bus.W_dstE = 4'($urandom);
    bus.e_valE = {$urandom, $urandom}; bus.m_valM = {$urandom, $urandom};
    bus.M_valE = {$urandom, $urandom}; bus.W_valM = {$urandom, $urandom};
    bus.W_valE = {$urandom, $urandom};
    bus.stall  = ($urandom_range(0, 4) == 0);
    bus.bubble = ($urandom_range(0, 4) == 0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    bus.stall = 1'b1;
    RST_N = 1'b0;
    tick();
    n_tests++;
    if (bus.E_icode !== 4'h1 || bus.E_dstE !== RN || bus.E_dstM !== RN ||
        bus.E_valA !== '0 || bus.load_use !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: icode=%h dstE=%h dstM=%h valA=%h lu=%b, want 1 f f 0 0",
               bus.E_icode, bus.E_dstE, bus.E_dstM, bus.E_valA, bus.load_use);
    end
    n_tests++;
    if (get_e() !== BUBBLE) begin
      n_fail++; $display("FAIL reset_all: got %h want %h", get_e(), BUBBLE);
    end
    RST_N = 1'b1;
    bus.stall = 1'b0;
  endtask

  task automatic test_fwd_priority();
    logic [DW-1:0] want [3];
    want = '{64'h11, 64'h22, 64'h33};
    clear_inputs();
    bus.D_icode = 4'h6; bus.D_srcA = 4'h3;
    bus.e_dstE = 4'h3; bus.e_valE = 64'h11;
    bus.M_dstM = 4'h3; bus.m_valM = 64'h22;
    bus.rf_valA = 64'h33;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) bus.e_dstE = RN;
      if (i == 2) bus.M_dstM = RN;
      tick();
      n_tests++;
      if (bus.E_valA !== want[i]) begin
        n_fail++; $display("FAIL fwd_priority[%0d]: got %h want %h", i, bus.E_valA, want[i]);
      end
    end
  endtask

  task automatic test_call_valp();
    clear_inputs();
    bus.D_icode = 4'h8; bus.D_valP = 64'h100; bus.D_srcA = 4'h4; bus.D_srcB = 4'h4;
    bus.e_dstE = 4'h4; bus.e_valE = 64'h55; bus.rf_valA = 64'h1; bus.rf_valB = 64'h2;
    tick();
    n_tests++;
    if (bus.E_valA !== 64'h100 || bus.E_valB !== 64'h55) begin
      n_fail++; $display("FAIL call_valp: valA=%h valB=%h want 100 55", bus.E_valA, bus.E_valB);
    end
  endtask

  task automatic test_rnone_writeback();
    clear_inputs();
    bus.D_icode = 4'h6; bus.D_srcB = RN; bus.W_dstE = RN; bus.W_valE = 64'h77;
    bus.rf_valB = 64'h9;
    tick();
    n_tests++;
    if (bus.E_valB !== 64'h9) begin
      n_fail++; $display("FAIL rnone: valB=%h want 9", bus.E_valB);
    end
    bus.D_srcA = 4'h5; bus.W_dstE = 4'h5; bus.W_valE = 64'hAB; bus.rf_valA = 64'h1;
    tick();
    n_tests++;
    if (bus.E_valA !== 64'hAB) begin
      n_fail++; $display("FAIL same_cycle_wb: valA=%h want ab", bus.E_valA);
    end
  endtask

  task automatic test_stall_bubble();
    e_t snap;
    clear_inputs();
    bus.D_icode = 4'h6; bus.D_srcA = RN; bus.rf_valA = 64'hA; bus.D_dstE = 4'h2;
    tick();
    snap = get_e();
    n_tests++;
    if (snap.icode !== 4'h6 || snap.valA !== 64'hA) begin
      n_fail++; $display("FAIL opq_load: icode=%h valA=%h want 6 a", snap.icode, snap.valA);
    end
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      bus.stall = 1'b1;
      bus.bubble = (i == 2);
      tick();
      n_tests++;
      if (get_e() !== snap) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got %h want %h", i, get_e(), snap);
      end
    end
    bus.stall = 1'b0; bus.bubble = 1'b1;
    tick();
    n_tests++;
    if (bus.E_icode !== 4'h1 || bus.E_dstE !== RN || bus.E_dstM !== RN) begin
      n_fail++; $display("FAIL bubble: icode=%h dstE=%h dstM=%h want 1 f f",
                         bus.E_icode, bus.E_dstE, bus.E_dstM);
    end
  endtask

  task automatic test_load_use();
    logic [3:0] icodes [4];
    logic [3:0] dstms  [4];
    logic       want   [4];
    icodes = '{4'h5, 4'h6, 4'h5, 4'hB};
    dstms  = '{4'h2, 4'h2, RN, 4'h2};
    want   = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      clear_inputs();
      bus.D_icode = icodes[i]; bus.D_dstM = dstms[i];
      tick();
      bus.D_icode = 4'h6; bus.D_srcA = 4'h7; bus.D_srcB = (i == 3) ? 4'h7 : 4'h2;
      if (i == 3) bus.D_srcA = 4'h2;
      #1;
      n_tests++;
      if (bus.load_use !== want[i]) begin
        n_fail++; $display("FAIL load_use[%0d]: got %b want %b", i, bus.load_use, want[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      rand_inputs();
      RST_N = ($urandom_range(0, 30) != 0);
      tick();
      n_tests++;
      if (get_e() !== exp_e || bus.load_use !== model_load_use()) begin
        n_fail++;
        $display("FAIL random[%0d]: e=%h lu=%b want e=%h lu=%b",
                 c, get_e(), bus.load_use, exp_e, model_load_use());
      end
      n_tests++;
      if (bus.d_srcA !== bus.D_srcA || bus.d_srcB !== bus.D_srcB) begin
        n_fail++;
        $display("FAIL d_src[%0d]: got %h %h want %h %h",
                 c, bus.d_srcA, bus.d_srcB, bus.D_srcA, bus.D_srcB);
      end
    end
    RST_N = 1'b1;
  endtask

  initial begin
    clear_inputs();
    exp_e = BUBBLE;
    @(negedge CLK);
    test_reset();
    test_fwd_priority();
    test_call_valp();
    test_rnone_writeback();
    test_stall_bubble();
    test_load_use();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
